alu_seq: RTL

Parametrised, clocked successor to the 8-bit combinational ALU, and the next-generation datapath engine for the basic processor.
- Operands are latched on a START handshake; results go into a registered OUT/OUT_HI pair.
- Flags are kept in a persistent flag register, so ADC/SBB can chain multi-precision arithmetic.
- Shifts execute one bit per cycle and multiply is shift-add; the controller stalls on BUSY until DONE.

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with a persistent flag register, a bit-serial shifter and a
// shift-add multiplier. Single-cycle ops finish on the accepting edge.
//
// state   | meaning
// S_IDLE  | waiting for START; single-cycle ops complete here
// S_SHIFT | one bit shifted per edge; cnt holds bits still to shift
// S_MUL   | one multiplier bit consumed per edge; cnt holds bits still to process
module alu_seq #(
  parameter int W       = 8,
  parameter int SHAMT_W = $clog2(W) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic [W-1:0] INPUTA,
  input  logic [W-1:0] INPUTB,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         BUSY,
  output logic         DONE,
  output logic         CARRY,
  output logic         ZERO,
  output logic         GREATER,
  output logic         NEG
);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_ADC = 4'd2,  OP_SUB = 4'd3,  OP_SBB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,  OP_MOV = 4'd8;
  localparam logic [3:0] OP_LSH = 4'd9,  OP_RSH = 4'd10, OP_ASR = 4'd11, OP_CMP = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [SHAMT_W-1:0] W_CNT   = SHAMT_W'(W);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q, op_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt, shamt;
  logic [W-1:0]     sh, sh_nxt, sh_step, mcand, mcand_nxt;
  logic             sh_out;
  logic [2*W-1:0]   prod, prod_nxt, mul_step;
  logic [W:0]       add_sum, sub_diff, mul_sum;
  logic [W-1:0]     out_nxt, hi_nxt;
  logic             done_nxt, carry_nxt, zero_nxt, greater_nxt, neg_nxt;

  assign BUSY = (state != S_IDLE);

  always_comb begin
    add_sum  = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, (OP == OP_ADC) & CARRY};
    sub_diff = {1'b0, INPUTA} - {1'b0, INPUTB} - {{W{1'b0}}, (OP == OP_SBB) & CARRY};
    shamt    = (INPUTB[SHAMT_W-1:0] > W_CNT) ? W_CNT : INPUTB[SHAMT_W-1:0];
    sh_out   = (op_q == OP_LSH) ? sh[W-1] : sh[0];
    if (op_q == OP_LSH) sh_step = {sh[W-2:0], 1'b0};
    else                sh_step = {(op_q == OP_ASR) & sh[W-1], sh[W-1:1]};
    // Classic shift-add: add the multiplicand into the high half, then shift the
    // whole product right, keeping the adder carry as the new top bit.
    mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    mul_step = {mul_sum, prod[W-1:1]};
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    cnt_nxt     = cnt;
    sh_nxt      = sh;
    mcand_nxt   = mcand;
    prod_nxt    = prod;
    out_nxt     = OUT;
    hi_nxt      = OUT_HI;
    done_nxt    = 1'b0;
    carry_nxt   = CARRY;
    zero_nxt    = ZERO;
    greater_nxt = GREATER;
    neg_nxt     = NEG;
    case (state)
      S_IDLE: if (START) begin
        done_nxt = 1'b1;
        case (OP)
          OP_ADD, OP_ADC: begin out_nxt = add_sum[W-1:0]; carry_nxt = add_sum[W]; hi_nxt = '0; end
          OP_SUB, OP_SBB: begin out_nxt = sub_diff[W-1:0]; carry_nxt = sub_diff[W]; hi_nxt = '0; end
          OP_AND: begin out_nxt = INPUTA & INPUTB; carry_nxt = 1'b0; hi_nxt = '0; end
          OP_OR:  begin out_nxt = INPUTA | INPUTB; carry_nxt = 1'b0; hi_nxt = '0; end
          OP_XOR: begin out_nxt = INPUTA ^ INPUTB; carry_nxt = 1'b0; hi_nxt = '0; end
          OP_MOV: begin out_nxt = INPUTA;          carry_nxt = 1'b0; hi_nxt = '0; end
          OP_LSH, OP_RSH, OP_ASR: begin
            if (shamt == '0) begin
              out_nxt   = INPUTA;
              carry_nxt = 1'b0;
              hi_nxt    = '0;
            end else begin
              done_nxt  = 1'b0;
              state_nxt = S_SHIFT;
              op_nxt    = OP;
              cnt_nxt   = shamt;
              sh_nxt    = INPUTA;
            end
          end
          OP_CMP: begin
            carry_nxt   = sub_diff[W];
            zero_nxt    = (INPUTA == INPUTB);
            greater_nxt = (INPUTA > INPUTB);
            neg_nxt     = sub_diff[W-1];
          end
          OP_MUL: begin
            done_nxt  = 1'b0;
            state_nxt = S_MUL;
            op_nxt    = OP;
            cnt_nxt   = W_CNT;
            mcand_nxt = INPUTA;
            prod_nxt  = {{W{1'b0}}, INPUTB};
          end
          default: ;
        endcase
        // NOP lands here too: flags follow the unchanged OUT, CARRY is kept for chaining.
        if (done_nxt && OP != OP_CMP) begin
          zero_nxt    = (out_nxt == '0);
          neg_nxt     = out_nxt[W-1];
          greater_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        sh_nxt  = sh_step;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt   = S_IDLE;
          done_nxt    = 1'b1;
          out_nxt     = sh_step;
          hi_nxt      = '0;
          carry_nxt   = sh_out;
          zero_nxt    = (sh_step == '0);
          neg_nxt     = sh_step[W-1];
          greater_nxt = 1'b0;
        end
      end
      S_MUL: begin
        prod_nxt = mul_step;
        cnt_nxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt   = S_IDLE;
          done_nxt    = 1'b1;
          out_nxt     = mul_step[W-1:0];
          hi_nxt      = mul_step[2*W-1:W];
          carry_nxt   = (mul_step[2*W-1:W] != '0);
          zero_nxt    = (mul_step == '0);
          neg_nxt     = mul_step[2*W-1];
          greater_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      cnt     <= '0;
      sh      <= '0;
      mcand   <= '0;
      prod    <= '0;
      OUT     <= '0;
      OUT_HI  <= '0;
      DONE    <= 1'b0;
      CARRY   <= 1'b0;
      ZERO    <= 1'b0;
      GREATER <= 1'b0;
      NEG     <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      mcand   <= mcand_nxt;
      prod    <= prod_nxt;
      OUT     <= out_nxt;
      OUT_HI  <= hi_nxt;
      DONE    <= done_nxt;
      CARRY   <= carry_nxt;
      ZERO    <= zero_nxt;
      GREATER <= greater_nxt;
      NEG     <= neg_nxt;
    end
  end

endmodule
